// File: rtl/insn_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit: default geometry and the
// queue entry layout {pc, insn}.
package insn_prefetch_unit_pkg;

  localparam int LEN_INSN      = 32;
  localparam int MEM_INSN_ADDR = 10;
  localparam int QDEPTH        = 4;
  localparam int RESET_PC      = 0;

  typedef struct packed {
    logic [MEM_INSN_ADDR-1:0] pc;
    logic [LEN_INSN-1:0]      insn;
  } fetch_entry_t;

endpackage

// File: rtl/insn_fetch_fifo.sv
// Fall-through FIFO for prefetched instructions: head is visible combinationally
// and reads as zero when empty. Flush empties it in one cycle.
module insn_fetch_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       not_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             pop_ok_s;

  assign pop_ok_s  = pop & (count_r != {CW{1'b0}});
  assign not_empty = (count_r != {CW{1'b0}});
  assign count     = count_r;
  assign head      = not_empty ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_r + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop_ok_s};
    end
  end

endmodule

// File: rtl/insn_prefetch_unit.sv
// Instruction prefetch unit: issues reads to a 1-cycle synchronous memory, queues
// {pc, insn} pairs and hands them to decode. Optional counters under FETCH_STATS_EN.
module insn_prefetch_unit #(
  parameter int LEN_INSN      = insn_prefetch_unit_pkg::LEN_INSN,
  parameter int MEM_INSN_ADDR = insn_prefetch_unit_pkg::MEM_INSN_ADDR,
  parameter int QDEPTH        = insn_prefetch_unit_pkg::QDEPTH,
  parameter int RESET_PC      = insn_prefetch_unit_pkg::RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en_i,
  input  logic                     redirect_i,
  input  logic [MEM_INSN_ADDR-1:0] redirect_pc_i,
  output logic                     mem_re_o,
  output logic [MEM_INSN_ADDR-1:0] mem_a_o,
  input  logic [LEN_INSN-1:0]      mem_q_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [LEN_INSN-1:0]      insn_o,
  output logic [MEM_INSN_ADDR-1:0] pc_o,
  output logic [31:0]              stat_fetch_o,
  output logic [31:0]              stat_bubble_o
);
  import insn_prefetch_unit_pkg::*;

  localparam int EW = MEM_INSN_ADDR + LEN_INSN;
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

  logic [MEM_INSN_ADDR-1:0] pc_r;
  logic [MEM_INSN_ADDR-1:0] tag_r;
  logic                     inflight_r;
  logic                     issue_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     valid_s;
  logic                     not_empty_s;
  logic [CW-1:0]            count_s;
  logic [CW:0]              occ_s;
  logic [EW-1:0]            head_s;

  // The in-flight word holds a slot, so a landing response can never overflow.
  assign occ_s    = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
  assign issue_s  = rst & fetch_en_i & ~redirect_i & (occ_s < QD);
  assign push_s   = inflight_r & ~redirect_i;
  assign valid_s  = not_empty_s & ~redirect_i;
  assign pop_s    = valid_s & ready_i;

  assign mem_re_o = issue_s;
  assign mem_a_o  = pc_r;
  assign valid_o  = valid_s;
  assign pc_o     = head_s[EW-1:LEN_INSN];
  assign insn_o   = head_s[LEN_INSN-1:0];

  // PC and in-flight tracking; a redirect kills the response due next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r       <= MEM_INSN_ADDR'(RESET_PC);
      tag_r      <= {MEM_INSN_ADDR{1'b0}};
      inflight_r <= 1'b0;
    end else if (redirect_i) begin
      pc_r       <= redirect_pc_i;
      inflight_r <= 1'b0;
    end else if (issue_s) begin
      pc_r       <= pc_r + {{(MEM_INSN_ADDR-1){1'b0}}, 1'b1};
      tag_r      <= pc_r;
      inflight_r <= 1'b1;
    end else begin
      inflight_r <= 1'b0;
    end
  end

  insn_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data ({tag_r, mem_q_i}),
    .pop       (pop_s),
    .flush     (redirect_i),
    .head      (head_s),
    .count     (count_s),
    .not_empty (not_empty_s)
  );

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetch_r;
  logic [31:0] stat_bubble_r;

  // Delivered-instruction and starved-cycle counters; free-running, wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetch_r  <= 32'd0;
      stat_bubble_r <= 32'd0;
    end else begin
      if (pop_s) stat_fetch_r <= stat_fetch_r + 32'd1;
      if (ready_i & ~valid_s) stat_bubble_r <= stat_bubble_r + 32'd1;
    end
  end

  assign stat_fetch_o  = stat_fetch_r;
  assign stat_bubble_o = stat_bubble_r;
`else
  assign stat_fetch_o  = 32'd0;
  assign stat_bubble_o = 32'd0;
`endif

endmodule
